// File: rtl/cpu_ad48_trap_unit_if.sv
// Commit-side trap port bundle: exception/ERET/CSR-write requests in, flush/redirect/CSR state out.
interface cpu_ad48_trap_unit_if;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [47:0] exc_pc;
  logic        eret_valid;
  logic        csr_we;
  logic [1:0]  csr_waddr;
  logic [47:0] csr_wdata;
  logic        flush;
  logic        redirect_valid;
  logic [47:0] redirect_pc;
  logic        busy;
  logic [47:0] csr_epc;
  logic [47:0] csr_cause;
  logic [47:0] csr_status;
  logic [1:0]  priv_mode;

  modport master (
    output exc_valid, exc_cause, exc_pc, eret_valid, csr_we, csr_waddr, csr_wdata,
    input  flush, redirect_valid, redirect_pc, busy, csr_epc, csr_cause, csr_status, priv_mode
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, eret_valid, csr_we, csr_waddr, csr_wdata,
    output flush, redirect_valid, redirect_pc, busy, csr_epc, csr_cause, csr_status, priv_mode
  );
endinterface

// File: rtl/cpu_ad48_trap_unit.sv
// Trap sequencer: commit exception/ERET -> CSR update, flush for FLUSH_CYCLES, one-cycle redirect.
// Requests arriving while busy belong to squashed instructions and are dropped.
module cpu_ad48_trap_unit #(
  parameter logic [47:0] TRAP_VECTOR  = 48'd32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  cpu_ad48_trap_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [47:0] target;
  logic [47:0] epc, cause, status, redirect_pc;
  logic [1:0]  priv;
  logic        flush, redirect_valid, busy;
  logic        flush_nxt, redirect_nxt, busy_nxt;
  logic        take_exc, take_eret, take_we;

  // Priority: exception over ERET over software CSR write; all gated to IDLE.
  assign take_exc  = (state == IDLE) && bus.exc_valid;
  assign take_eret = (state == IDLE) && !bus.exc_valid && bus.eret_valid;
  assign take_we   = (state == IDLE) && !bus.exc_valid && !bus.eret_valid && bus.csr_we;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take_exc || take_eret) state_nxt = FLUSH;
      FLUSH:    if (cnt == FLUSH_LAST) state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they come straight off flops.
  always_comb begin
    flush_nxt    = (state_nxt == FLUSH);
    redirect_nxt = (state_nxt == REDIRECT);
    busy_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
      redirect_pc    <= 48'd0;
      cnt            <= 4'd0;
    end else begin
      flush          <= flush_nxt;
      redirect_valid <= redirect_nxt;
      busy           <= busy_nxt;
      if (state == FLUSH && cnt == FLUSH_LAST) redirect_pc <= target;
      if (take_exc || take_eret)                cnt <= 4'd1;
      else if (state == FLUSH && cnt != FLUSH_LAST) cnt <= cnt + 4'd1;
      else if (state == REDIRECT)               cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epc    <= 48'd0;
      cause  <= 48'd0;
      status <= 48'd3;
      priv   <= 2'd3;
      target <= 48'd0;
    end else if (take_exc) begin
      epc    <= bus.exc_pc;
      cause  <= {44'd0, bus.exc_cause};
      status <= {status[47:4], priv, 2'd3};
      priv   <= 2'd3;
      target <= TRAP_VECTOR;
    end else if (take_eret) begin
      // Single saved level: previous priv is restored and then cleared to user.
      priv   <= status[3:2];
      status <= {status[47:4], 2'd0, status[3:2]};
      target <= epc;
    end else if (take_we) begin
      case (bus.csr_waddr)
        2'd0: epc   <= bus.csr_wdata;
        2'd1: cause <= bus.csr_wdata;
        2'd2: begin
          status <= bus.csr_wdata;
          priv   <= bus.csr_wdata[1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.flush          = flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.busy           = busy;
  assign bus.csr_epc        = epc;
  assign bus.csr_cause      = cause;
  assign bus.csr_status     = status;
  assign bus.priv_mode      = priv;

endmodule

// File: tb/tb_cpu_ad48_trap_unit.sv
// Directed and random stimulus against a cycle-level reference model of the trap sequencer.
module tb_cpu_ad48_trap_unit;
  localparam int FC = 2;
  localparam logic [47:0] VEC = 48'd32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  cpu_ad48_trap_unit_if bus();

  cpu_ad48_trap_unit #(.TRAP_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase counts cycles since the request (0 = idle).
  int          m_phase = 0;
  logic [47:0] m_epc = '0, m_cause = '0, m_status = 48'd3, m_tgt = '0, m_rpc = '0;
  logic [1:0]  m_priv = 2'd3;

  task automatic model_update();
    if (rst) begin
      m_phase = 0; m_epc = '0; m_cause = '0; m_status = 48'd3; m_priv = 2'd3; m_rpc = '0;
    end else if (m_phase == 0) begin
      if (bus.exc_valid) begin
        m_epc    = bus.exc_pc;
        m_cause  = 48'(bus.exc_cause);
        m_status = (m_status & ~48'hF) | (48'(m_priv) << 2) | 48'h3;
        m_priv   = 2'd3;
        m_tgt    = VEC;
        m_phase  = 1;
      end else if (bus.eret_valid) begin
        m_tgt    = m_epc;
        m_priv   = m_status[3:2];
        m_status = (m_status & ~48'hF) | 48'(m_status[3:2]);
        m_phase  = 1;
      end else if (bus.csr_we) begin
        if (bus.csr_waddr == 2'd0) m_epc = bus.csr_wdata;
        if (bus.csr_waddr == 2'd1) m_cause = bus.csr_wdata;
        if (bus.csr_waddr == 2'd2) begin
          m_status = bus.csr_wdata;
          m_priv   = bus.csr_wdata[1:0];
        end
      end
    end else if (m_phase <= FC) begin
      m_phase = m_phase + 1;
      if (m_phase == FC + 1) m_rpc = m_tgt;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("flush",          48'(bus.flush),          48'(m_phase >= 1 && m_phase <= FC));
    check("redirect_valid", 48'(bus.redirect_valid), 48'(m_phase == FC + 1));
    check("redirect_pc",    bus.redirect_pc,         m_rpc);
    check("busy",           48'(bus.busy),           48'(m_phase != 0));
    check("csr_epc",        bus.csr_epc,             m_epc);
    check("csr_cause",      bus.csr_cause,           m_cause);
    check("csr_status",     bus.csr_status,          m_status);
    check("priv_mode",      48'(bus.priv_mode),      48'(m_priv));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic exc, input logic [3:0] c, input logic [47:0] pc,
                       input logic eret, input logic we, input logic [1:0] wa,
                       input logic [47:0] wd);
    bus.exc_valid = exc; bus.exc_cause = c; bus.exc_pc = pc; bus.eret_valid = eret;
    bus.csr_we = we; bus.csr_waddr = wa; bus.csr_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 48'd0, 1'b0, 1'b0, 2'd0, 48'd0);
  endtask

  int redirects;
  logic [47:0] rnd;

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    check("reset_status", bus.csr_status, 48'd3);
    rst = 1'b0;

    // 1: user mode trap, cause 2, pc 0
    drive(1'b0, 4'd0, 48'd0, 1'b0, 1'b1, 2'd2, 48'd0); step();
    check("t1_priv_user", 48'(bus.priv_mode), 48'd0);
    drive(1'b1, 4'd2, 48'd0, 1'b0, 1'b0, 2'd0, 48'd0); step();
    check("t1_cause", bus.csr_cause, 48'd2);
    check("t1_status", bus.csr_status, 48'd3);
    idle(); step(); step();
    check("t1_redirect_valid", 48'(bus.redirect_valid), 48'd1);
    check("t1_redirect_pc", bus.redirect_pc, 48'd32);
    step();

    // 2: trap from machine mode
    drive(1'b1, 4'd3, 48'h5, 1'b0, 1'b0, 2'd0, 48'd0); step();
    check("t2_status", bus.csr_status, 48'hF);
    idle(); repeat (3) step();

    // 3: trap from user then ERET
    drive(1'b0, 4'd0, 48'd0, 1'b0, 1'b1, 2'd2, 48'd0); step();
    drive(1'b1, 4'd6, 48'h2, 1'b0, 1'b0, 2'd0, 48'd0); step();
    idle(); repeat (3) step();
    drive(1'b0, 4'd0, 48'd0, 1'b1, 1'b0, 2'd0, 48'd0); step();
    check("t3_priv", 48'(bus.priv_mode), 48'd0);
    check("t3_status", bus.csr_status, 48'd0);
    idle(); step(); step();
    check("t3_redirect_pc", bus.redirect_pc, 48'h2);
    step();

    // 4: exc + eret + csr write in one cycle
    drive(1'b1, 4'd4, 48'h9, 1'b1, 1'b1, 2'd0, 48'h77); step();
    check("t4_epc", bus.csr_epc, 48'h9);
    idle(); repeat (3) step();

    // 5: exception during flush is ignored
    drive(1'b1, 4'd2, 48'h11, 1'b0, 1'b0, 2'd0, 48'd0); step();
    drive(1'b1, 4'd3, 48'h40, 1'b0, 1'b0, 2'd0, 48'd0); step();
    idle();
    redirects = 0;
    repeat (4) begin
      step();
      if (bus.redirect_valid) redirects++;
    end
    check("t5_epc", bus.csr_epc, 48'h11);
    check("t5_single_redirect", 48'(redirects), 48'd1);

    // 6: reset during flush
    drive(1'b1, 4'd2, 48'h33, 1'b0, 1'b0, 2'd0, 48'd0); step();
    idle(); rst = 1'b1; step();
    check("t6_flush", 48'(bus.flush), 48'd0);
    check("t6_epc", bus.csr_epc, 48'd0);
    rst = 1'b0;
    redirects = 0;
    repeat (3) begin
      step();
      if (bus.redirect_valid) redirects++;
    end
    check("t6_no_redirect", 48'(redirects), 48'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      drive($urandom_range(0, 5) == 0, 4'($urandom), 48'({$urandom, $urandom}),
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 2'($urandom), rnd);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
